// File: rtl/cvxif_kernel_dispatcher.sv
// cvxif_kernel_dispatcher: routes CV-X-IF ops to one of NUM_KERNELS HLS kernels and buffers their output.
// Rev 1.0
`default_nettype none

module cvxif_kernel_dispatcher #(
    parameter int NUM_KERNELS = 4,
    parameter int DATA_W      = 64,
    parameter int OP_W        = $clog2(NUM_KERNELS) + 1,
    parameter int OUT_DEPTH   = 4,
    parameter int CNT_W       = 16
) (
    input  logic                          ap_clk_i,
    input  logic                          ap_rst_n_i,
    input  logic                          fire_i,
    input  logic [OP_W-1:0]               opcode_i,
    output logic                          busy_o,
    output logic                          err_opcode_o,
    output logic                          err_busy_o,
    input  logic                          ap_start_i,
    output logic                          ap_done_o,
    output logic                          ap_idle_o,
    output logic                          ap_ready_o,
    input  logic [DATA_W-1:0]             in1_dout_i,
    input  logic [DATA_W-1:0]             in2_dout_i,
    input  logic                          in1_empty_n_i,
    input  logic                          in2_empty_n_i,
    output logic                          in1_read_o,
    output logic                          in2_read_o,
    output logic [DATA_W-1:0]             out_r_din_o,
    input  logic                          out_r_full_n_i,
    output logic                          out_r_write_o,
    output logic [NUM_KERNELS-1:0]        k_ap_start_o,
    input  logic [NUM_KERNELS-1:0]        k_ap_done_i,
    input  logic [NUM_KERNELS-1:0]        k_ap_idle_i,
    input  logic [NUM_KERNELS-1:0]        k_ap_ready_i,
    output logic [NUM_KERNELS-1:0]        k_in1_empty_n_o,
    output logic [NUM_KERNELS-1:0]        k_in2_empty_n_o,
    input  logic [NUM_KERNELS-1:0]        k_in1_read_i,
    input  logic [NUM_KERNELS-1:0]        k_in2_read_i,
    input  logic [NUM_KERNELS*DATA_W-1:0] k_out_din_i,
    input  logic [NUM_KERNELS-1:0]        k_out_write_i,
    output logic [NUM_KERNELS-1:0]        k_out_full_n_o,
    output logic [CNT_W-1:0]              in_beats_o,
    output logic [CNT_W-1:0]              out_beats_o
);

    localparam int SEL_W = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1;
    localparam int AW    = $clog2(OUT_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   in_beats_q, in_beats_d;
    logic [CNT_W-1:0]   out_beats_q, out_beats_d;
    logic               err_opcode_q, err_opcode_d;
    logic               err_busy_q, err_busy_d;
    logic [DATA_W-1:0]  mem_q [OUT_DEPTH];

    logic w_run;
    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_k_done;
    logic w_op_ok;

    // Kernels tap the input stream data directly; only handshakes pass through here.
    logic unused_inputs;
    assign unused_inputs = ^{in1_dout_i, in2_dout_i, k_ap_idle_i};

    assign w_run    = (state_q == S_RUN);
    assign w_empty  = (wr_ptr_q == rd_ptr_q);
    assign w_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_push   = w_run && k_out_write_i[sel_q] && !w_full;
    assign w_pop    = !w_empty && out_r_full_n_i;
    assign w_k_done = w_run && k_ap_done_i[sel_q];
    assign w_op_ok  = (32'(opcode_i) < NUM_KERNELS);

    assign ap_idle_o     = (state_q == S_IDLE);
    assign busy_o        = !ap_idle_o;
    assign err_opcode_o  = err_opcode_q;
    assign err_busy_o    = err_busy_q;
    assign ap_ready_o    = w_run && k_ap_ready_i[sel_q];
    assign in1_read_o    = w_run && k_in1_read_i[sel_q];
    assign in2_read_o    = w_run && k_in2_read_i[sel_q];
    assign out_r_write_o = w_pop;
    assign out_r_din_o   = w_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign in_beats_o    = in_beats_q;
    assign out_beats_o   = out_beats_q;

    genvar i;
    generate
        for (i = 0; i < NUM_KERNELS; i++) begin : g_route
            localparam logic [SEL_W-1:0] IDX = SEL_W'(i);
            logic w_hit;
            assign w_hit              = w_run && (sel_q == IDX);
            assign k_ap_start_o[i]    = w_hit && ap_start_i;
            assign k_in1_empty_n_o[i] = w_hit && in1_empty_n_i;
            assign k_in2_empty_n_o[i] = w_hit && in2_empty_n_i;
            assign k_out_full_n_o[i]  = w_hit && !w_full;
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        in_beats_d   = in_beats_q;
        out_beats_d  = out_beats_q;
        err_opcode_d = 1'b0;
        err_busy_d   = 1'b0;
        ap_done_o    = 1'b0;

        if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (in1_read_o && (in_beats_q != '1))
            in_beats_d = in_beats_q + 1'b1;
        if (w_pop && (out_beats_q != '1))
            out_beats_d = out_beats_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (fire_i) begin
                    if (w_op_ok) begin
                        sel_d       = opcode_i[SEL_W-1:0];
                        in_beats_d  = '0;
                        out_beats_d = '0;
                        state_d     = S_RUN;
                    end else begin
                        err_opcode_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                // Done can only be reported immediately if nothing is left or arriving.
                if (w_k_done) begin
                    if (w_empty && !w_push) begin
                        ap_done_o = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_empty) begin
                    ap_done_o = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fire_i && (state_q != S_IDLE))
            err_busy_d = 1'b1;
    end

    always_ff @(posedge ap_clk_i) begin
        if (!ap_rst_n_i) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            in_beats_q   <= '0;
            out_beats_q  <= '0;
            err_opcode_q <= 1'b0;
            err_busy_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            in_beats_q   <= in_beats_d;
            out_beats_q  <= out_beats_d;
            err_opcode_q <= err_opcode_d;
            err_busy_q   <= err_busy_d;
        end
    end

    always_ff @(posedge ap_clk_i) begin
        if (w_push)
            mem_q[wr_ptr_q[AW-1:0]] <= k_out_din_i[sel_q*DATA_W +: DATA_W];
    end

endmodule

`default_nettype wire

// File: tb/tb_cvxif_kernel_dispatcher.sv
// tb_cvxif_kernel_dispatcher: directed stimulus with a queue-based output scoreboard.
// Rev 1.0
`default_nettype none

module tb_cvxif_kernel_dispatcher;

    localparam int NK = 4;
    localparam int DW = 64;
    localparam int OW = 3;
    localparam int CW = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             fire = 1'b0;
    logic [OW-1:0]    opcode = '0;
    logic             busy, err_opcode, err_busy;
    logic             ap_start = 1'b0;
    logic             ap_done, ap_idle, ap_ready;
    logic [DW-1:0]    in1_dout = 64'h1111, in2_dout = 64'h2222;
    logic             in1_empty_n = 1'b0, in2_empty_n = 1'b0;
    logic             in1_read, in2_read;
    logic [DW-1:0]    out_r_din;
    logic             out_r_full_n = 1'b1;
    logic             out_r_write;
    logic [NK-1:0]    k_ap_start;
    logic [NK-1:0]    k_ap_done = '0, k_ap_idle = '1, k_ap_ready = '0;
    logic [NK-1:0]    k_in1_empty_n, k_in2_empty_n;
    logic [NK-1:0]    k_in1_read = '0, k_in2_read = '0;
    logic [NK*DW-1:0] k_out_din = '0;
    logic [NK-1:0]    k_out_write = '0;
    logic [NK-1:0]    k_out_full_n;
    logic [CW-1:0]    in_beats, out_beats;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int exp_done = 0;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    cvxif_kernel_dispatcher #(
        .NUM_KERNELS(NK), .DATA_W(DW), .OP_W(OW), .OUT_DEPTH(4), .CNT_W(CW)
    ) dut (
        .ap_clk_i(clk), .ap_rst_n_i(rst_n), .fire_i(fire), .opcode_i(opcode),
        .busy_o(busy), .err_opcode_o(err_opcode), .err_busy_o(err_busy),
        .ap_start_i(ap_start), .ap_done_o(ap_done), .ap_idle_o(ap_idle), .ap_ready_o(ap_ready),
        .in1_dout_i(in1_dout), .in2_dout_i(in2_dout),
        .in1_empty_n_i(in1_empty_n), .in2_empty_n_i(in2_empty_n),
        .in1_read_o(in1_read), .in2_read_o(in2_read),
        .out_r_din_o(out_r_din), .out_r_full_n_i(out_r_full_n), .out_r_write_o(out_r_write),
        .k_ap_start_o(k_ap_start), .k_ap_done_i(k_ap_done), .k_ap_idle_i(k_ap_idle),
        .k_ap_ready_i(k_ap_ready),
        .k_in1_empty_n_o(k_in1_empty_n), .k_in2_empty_n_o(k_in2_empty_n),
        .k_in1_read_i(k_in1_read), .k_in2_read_i(k_in2_read),
        .k_out_din_i(k_out_din), .k_out_write_i(k_out_write), .k_out_full_n_o(k_out_full_n),
        .in_beats_o(in_beats), .out_beats_o(out_beats)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every delivered beat must match the oldest expected one.
    always @(negedge clk) begin
        if (out_r_write) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got %0h expected no write", out_r_din);
            end else begin
                check("out_data", out_r_din, exp_q.pop_front());
            end
        end
        if (ap_done) begin
            done_seen++;
            check("done_after_drain", 64'(exp_q.size()), 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fire_op(input logic [OW-1:0] op);
        fire   = 1'b1;
        opcode = op;
        tick();
        fire   = 1'b0;
    endtask

    task automatic kwrite(input int k, input logic [DW-1:0] d, input bit expect_out);
        bit acc = 1'b0;
        k_out_write[k]          = 1'b1;
        k_out_din[k*DW +: DW]   = d;
        if (expect_out) exp_q.push_back(d);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (k_out_full_n[k]) begin
                acc = 1'b1;
                break;
            end
        end
        check("kwrite_accept", 64'(acc), 64'd1);
        @(posedge clk);
        #1;
        k_out_write[k] = 1'b0;
    endtask

    task automatic kdone(input int k);
        k_ap_done[k] = 1'b1;
        exp_done++;
        tick();
        k_ap_done[k] = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!ap_idle && n < 200) begin
            tick();
            n++;
        end
        check(name, 64'(ap_idle), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        @(negedge clk);
        check("rst_idle", ap_idle, 1);
        check("rst_busy", busy, 0);
        check("rst_done", ap_done, 0);
        check("rst_write", out_r_write, 0);
        check("rst_kstart", k_ap_start, 0);
        check("rst_in_beats", in_beats, 0);
        rst_n = 1'b1;
        tick();

        // Reset while RUN with three beats parked in the buffer
        fire_op(1);
        out_r_full_n = 1'b0;
        kwrite(1, 64'h1, 0);
        kwrite(1, 64'h2, 0);
        kwrite(1, 64'h3, 0);
        @(negedge clk);
        check("t1_busy_before", busy, 1);
        rst_n = 1'b0;
        tick();
        out_r_full_n = 1'b1;
        @(negedge clk);
        check("t1_idle", ap_idle, 1);
        check("t1_write", out_r_write, 0);
        check("t1_out_beats", out_beats, 0);
        check("t1_busy", busy, 0);
        check("t1_din", out_r_din, 0);
        rst_n = 1'b1;
        tick();

        // Plain op on kernel 1: two input reads, three outputs
        fire_op(1);
        ap_start = 1'b1;
        @(negedge clk);
        check("t2_kstart", k_ap_start, 4'b0010);
        tick();
        ap_start = 1'b0;
        in1_empty_n = 1'b1;
        k_in1_read[1] = 1'b1;
        @(negedge clk);
        check("t2_k_empty_n", k_in1_empty_n, 4'b0010);
        check("t2_in1_read", in1_read, 1);
        tick();
        tick();
        k_in1_read[1] = 1'b0;
        in1_empty_n = 1'b0;
        kwrite(1, 64'hA, 1);
        kwrite(1, 64'hB, 1);
        kwrite(1, 64'hC, 1);
        kdone(1);
        wait_idle("t2_idle");
        check("t2_in_beats", in_beats, 2);
        check("t2_out_beats", out_beats, 3);
        check("t2_done_count", 64'(done_seen), 64'(exp_done));

        // Downstream stalls while the kernel produces six beats
        fire_op(1);
        out_r_full_n = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) kwrite(1, 64'h10 + 64'(i), 1);
            end
            begin
                repeat (6) tick();
                @(negedge clk);
                check("t3_full_n", k_out_full_n[1], 0);
                check("t3_hold", out_r_write, 0);
                repeat (4) tick();
                out_r_full_n = 1'b1;
            end
        join
        kdone(1);
        wait_idle("t3_idle");
        check("t3_out_beats", out_beats, 6);
        check("t3_done_count", 64'(done_seen), 64'(exp_done));

        // Out-of-range opcode
        ap_start = 1'b1;
        fire_op(3'd4);
        @(negedge clk);
        check("t4_err_opcode", err_opcode, 1);
        check("t4_busy", busy, 0);
        check("t4_kstart", k_ap_start, 0);
        tick();
        @(negedge clk);
        check("t4_err_clear", err_opcode, 0);
        ap_start = 1'b0;
        tick();

        // Fire while busy must be ignored
        fire_op(1);
        ap_start = 1'b1;
        in1_empty_n = 1'b1;
        in2_empty_n = 1'b1;
        fire = 1'b1;
        opcode = 3'd2;
        tick();
        fire = 1'b0;
        @(negedge clk);
        check("t5_err_busy", err_busy, 1);
        check("t5_kstart", k_ap_start, 4'b0010);
        check("t5_k_in1_empty_n", k_in1_empty_n, 4'b0010);
        check("t5_k_in2_empty_n", k_in2_empty_n, 4'b0010);
        tick();
        @(negedge clk);
        check("t5_err_clear", err_busy, 0);
        tick();

        // Done with empty buffer completes the same cycle; immediate refire
        k_ap_done[1] = 1'b1;
        k_ap_ready[1] = 1'b1;
        exp_done++;
        @(negedge clk);
        check("t6_done_same_cycle", ap_done, 1);
        check("t6_ready", ap_ready, 1);
        tick();
        k_ap_done[1] = 1'b0;
        k_ap_ready[1] = 1'b0;
        fire = 1'b1;
        opcode = 3'd0;
        @(negedge clk);
        check("t6_idle", ap_idle, 1);
        tick();
        fire = 1'b0;
        @(negedge clk);
        check("t6_refire_busy", busy, 1);
        check("t6_refire_kstart", k_ap_start, 4'b0001);
        check("t6_no_err", err_busy, 0);
        kdone(0);
        wait_idle("t6_final_idle");
        ap_start = 1'b0;
        in1_empty_n = 1'b0;
        in2_empty_n = 1'b0;
        tick();

        check("end_done_count", 64'(done_seen), 64'(exp_done));
        check("end_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
